// File: rtl/conv_acc_seq_if.sv
// Stream bundle for the convolution sequencer: job command, tile input stream
// and result output stream, all valid/ready.
interface conv_acc_seq_if #(
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_tiles;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  cmd_valid, cmd_tiles, s_data, s_valid, m_ready,
        output cmd_ready, s_ready, m_data, m_valid
    );

    modport master (
        output cmd_valid, cmd_tiles, s_data, s_valid, m_ready,
        input  cmd_ready, s_ready, m_data, m_valid
    );
endinterface

// File: rtl/conv_acc_seq.sv
// Tile sequencer for the 4x4 systolic array: buffers a weight tile and data tiles,
// replays each as a gap-free burst, and guards the result FIFO with credits.
module conv_acc_seq #(
    parameter int DATA_W     = 64,
    parameter int W_BEATS    = 9,
    parameter int TILE_BEATS = 12,
    parameter int RES_BEATS  = 4,
    parameter int OUT_DEPTH  = 8,
    parameter int BUF_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    conv_acc_seq_if.slave     bus,
    output logic              acc_rst,
    output logic              acc_weight_setup,
    output logic [DATA_W-1:0] acc_data,
    input  logic [DATA_W-1:0] acc_out,
    input  logic              acc_out_en,
    output logic              busy,
    output logic              done,
    output logic              err_overflow
);
    localparam int FAW = $clog2(OUT_DEPTH);
    localparam int CW  = FAW + 1;

    typedef logic [BUF_AW:0]   wcnt_t;
    typedef logic [BUF_AW-1:0] rptr_t;
    typedef logic [CW-1:0]     cnt_t;
    typedef logic [CW:0]       sum_t;

    localparam wcnt_t W_N   = wcnt_t'(W_BEATS);
    localparam wcnt_t T_N   = wcnt_t'(TILE_BEATS);
    localparam rptr_t W_END = rptr_t'(W_BEATS - 1);
    localparam rptr_t T_END = rptr_t'(TILE_BEATS - 1);

    typedef enum logic [2:0] {IDLE, CLR, FILL_W, BURST_W, FILL_D, BURST_D, WAIT_RES, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] tile_buf [2**BUF_AW];
    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [DATA_W-1:0] acc_data_p1;
    wcnt_t             wr_cnt, need_n;
    rptr_t             rd_ptr;
    logic [15:0]       tiles_left;
    cnt_t              fifo_cnt, outstanding, out_nx;
    logic [FAW-1:0]    fifo_wp, fifo_rp;
    logic              in_fill, in_burst, burst_last, have_all, credit_ok;
    logic              s_rdy, accept, cmd_hs, burst_entry, fill_exit;
    logic              fifo_full, push, pop;

    // Results still owed by the array; an unsolicited beat never drives it below zero.
    function automatic cnt_t out_update(input cnt_t cur, input logic entry, input logic res);
        cnt_t nxt;
        nxt = cur + (entry ? cnt_t'(RES_BEATS) : cnt_t'(0));
        if (res && nxt != cnt_t'(0))
            nxt = nxt - cnt_t'(1);
        return nxt;
    endfunction

    assign in_fill    = (state == FILL_W) || (state == FILL_D);
    assign in_burst   = (state == BURST_W) || (state == BURST_D);
    assign need_n     = (state == FILL_W) ? W_N : T_N;
    assign s_rdy      = in_fill && (wr_cnt < need_n);
    assign accept     = bus.s_valid && s_rdy;
    assign cmd_hs     = (state == IDLE) && bus.cmd_valid;
    assign have_all   = (wr_cnt == need_n) || (accept && (wr_cnt == need_n - wcnt_t'(1)));
    assign burst_last = rd_ptr == ((state == BURST_W) ? W_END : T_END);
    assign credit_ok  = (sum_t'(fifo_cnt) + sum_t'(outstanding) + sum_t'(RES_BEATS)) <= sum_t'(OUT_DEPTH);

    assign fifo_full = fifo_cnt == cnt_t'(OUT_DEPTH);
    assign push      = acc_out_en && !fifo_full;
    assign pop       = (fifo_cnt != cnt_t'(0)) && bus.m_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.cmd_valid) state_nx = CLR;
            CLR:      state_nx = FILL_W;
            FILL_W:   if (have_all) state_nx = BURST_W;
            BURST_W:  if (burst_last) state_nx = (tiles_left != 16'd0) ? FILL_D : DONE;
            FILL_D:   if (have_all && credit_ok) state_nx = BURST_D;
            BURST_D:  if (burst_last) state_nx = (tiles_left > 16'd1) ? FILL_D : WAIT_RES;
            WAIT_RES: if (out_nx == cnt_t'(0)) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign burst_entry = (state == FILL_D) && (state_nx == BURST_D);
    assign fill_exit   = burst_entry || ((state == FILL_W) && (state_nx == BURST_W));
    assign out_nx      = out_update(outstanding, burst_entry, acc_out_en);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            tiles_left   <= '0;
            outstanding  <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_cnt      <= in_fill ? (wr_cnt + wcnt_t'(accept)) : '0;
            rd_ptr      <= (in_burst && !burst_last) ? rd_ptr + rptr_t'(1) : '0;
            outstanding <= out_nx;
            if (cmd_hs)
                tiles_left <= bus.cmd_tiles;
            else if (state == BURST_D && burst_last)
                tiles_left <= tiles_left - 16'd1;
            if (acc_out_en && fifo_full)
                err_overflow <= 1'b1;
            else if (cmd_hs)
                err_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tile_buf[wr_cnt[BUF_AW-1:0]] <= bus.s_data;
    end

    // Stage p1: beat 0 is prefetched as the fill completes so the burst has no bubble.
    always_ff @(posedge clk) begin
        if (rst)
            acc_data_p1 <= '0;
        else if (fill_exit)
            acc_data_p1 <= tile_buf[0];
        else if (in_burst && !burst_last)
            acc_data_p1 <= tile_buf[rd_ptr + rptr_t'(1)];
        else
            acc_data_p1 <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            fifo_wp  <= fifo_wp + FAW'(push);
            fifo_rp  <= fifo_rp + FAW'(pop);
            fifo_cnt <= fifo_cnt + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wp] <= acc_out;
    end

    assign acc_data         = acc_data_p1;
    assign acc_rst          = rst || (state == CLR);
    assign acc_weight_setup = !rst && ((state == CLR) || (state == BURST_W));
    assign busy             = state != IDLE;
    assign done             = state == DONE;
    assign bus.cmd_ready    = state == IDLE;
    assign bus.s_ready      = s_rdy;
    assign bus.m_valid      = fifo_cnt != cnt_t'(0);
    assign bus.m_data       = fifo_mem[fifo_rp];
endmodule

// File: tb/tb_conv_acc_seq.sv
// Scoreboard bench for conv_acc_seq with a behavioural array model that sums
// each received data tile and returns RES_BEATS results per tile.
module tb_conv_acc_seq;
    localparam logic [63:0] WT = 64'h0001_0002_0003_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_rst, acc_weight_setup, acc_out_en, busy, done, err_overflow;
    logic [63:0] acc_data, acc_out;

    conv_acc_seq_if bus ();

    conv_acc_seq dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .acc_rst          (acc_rst),
        .acc_weight_setup (acc_weight_setup),
        .acc_data         (acc_data),
        .acc_out          (acc_out),
        .acc_out_en       (acc_out_en),
        .busy             (busy),
        .done             (done),
        .err_overflow     (err_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] sb_q [$];
    logic [63:0] res_q [$];
    int          run_len = 0;
    logic        run_w = 1'b0;
    logic [63:0] run_sum = '0;
    int          data_runs = 0, w_runs = 0, wsetup_cycles = 0;
    int          last_res_cyc = 0, last_w_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string why);
        checks++;
        errors++;
        $display("FAIL %s %s", nm, why);
    endtask

    // Array model: replays queued results and checks every burst it receives.
    initial begin
        acc_out_en = 1'b0;
        acc_out    = '0;
        forever begin
            @(negedge clk);
            if (res_q.size() > 0 && rst !== 1'b1) begin
                acc_out_en   = 1'b1;
                acc_out      = res_q.pop_front();
                last_res_cyc = cyc;
            end else begin
                acc_out_en = 1'b0;
                acc_out    = '0;
            end
            #2;
            if (rst !== 1'b0) begin
                run_len = 0;
            end else begin
                if (acc_weight_setup) wsetup_cycles++;
                if (acc_data != 64'd0) begin
                    if (run_len == 0) begin
                        run_w   = acc_weight_setup;
                        run_sum = '0;
                    end
                    run_len++;
                    run_sum += acc_data;
                    if (run_w) begin
                        chk("weight_beat", acc_data, WT);
                        last_w_cyc = cyc;
                    end else if (run_len == 12) begin
                        for (int k = 0; k < 4; k++) res_q.push_back(run_sum + 64'(k));
                    end
                end else if (run_len > 0) begin
                    chk(run_w ? "weight_burst_len" : "data_burst_len", 64'(run_len), run_w ? 64'd9 : 64'd12);
                    if (run_w) w_runs++;
                    else       data_runs++;
                    run_len = 0;
                end
            end
        end
    end

    // Output monitor: every accepted result must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) fail("result_unexpected", $sformatf("got %h with empty scoreboard", bus.m_data));
                else                  chk("result", bus.m_data, sb_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [15:0] n);
        int guard;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_tiles = n;
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail("cmd_timeout", "cmd_ready never rose");
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #2;
        chk("clr_acc_rst", 64'(acc_rst), 64'd1);
        chk("clr_wsetup", 64'(acc_weight_setup), 64'd1);
        chk("clr_s_ready", 64'(bus.s_ready), 64'd0);
        chk("clr_err_cleared", 64'(err_overflow), 64'd0);
        @(negedge clk);
        #2;
        chk("fill_s_ready", 64'(bus.s_ready), 64'd1);
        chk("fill_acc_rst", 64'(acc_rst), 64'd0);
    endtask

    task automatic send_beat(input logic [63:0] d, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        guard = 0;
        while (!bus.s_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) fail("beat_timeout", "s_ready never rose");
        else              @(posedge clk);
    endtask

    task automatic send_tiles(input int n, input int gap, input logic [15:0] base, input bit expect_res);
        logic [63:0] d, sum;
        for (int i = 0; i < 9; i++) send_beat(WT, gap);
        for (int t = 0; t < n; t++) begin
            sum = '0;
            for (int j = 0; j < 12; j++) sum += {base + 16'(t), 16'(j), 16'hA5A5, 16'(j + 1)};
            if (expect_res)
                for (int k = 0; k < 4; k++) sb_q.push_back(sum + 64'(k));
            for (int j = 0; j < 12; j++) begin
                d = {base + 16'(t), 16'(j), 16'hA5A5, 16'(j + 1)};
                send_beat(d, gap);
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int guard;
        guard = 0;
        dcyc  = 0;
        while (guard < 400) begin
            @(negedge clk);
            #2;
            if (done) break;
            guard++;
        end
        if (guard >= 400) begin
            fail("done_timeout", "no done pulse");
        end else begin
            dcyc = cyc;
            @(negedge clk);
            #2;
            chk("done_pulse_width", 64'(done), 64'd0);
            chk("post_cmd_ready", 64'(bus.cmd_ready), 64'd1);
            chk("post_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || bus.m_valid) && guard < 300) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (guard >= 300) fail("drain_timeout", $sformatf("%0d results still expected", sb_q.size()));
    endtask

    initial begin
        int dcyc;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_tiles = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_acc_rst", 64'(acc_rst), 64'd1);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
        chk("idle_wsetup", 64'(acc_weight_setup), 64'd0);
        chk("idle_acc_data", acc_data, 64'd0);
        chk("idle_acc_rst", 64'(acc_rst), 64'd0);
        chk("idle_busy_done", {62'd0, busy, done}, 64'd0);
        chk("idle_err", 64'(err_overflow), 64'd0);

        // One tile, back-to-back input.
        wsetup_cycles = 0; data_runs = 0;
        send_cmd(16'd1);
        send_tiles(1, 0, 16'h0100, 1'b1);
        wait_done(dcyc);
        chk("done_after_last_result", 64'(dcyc - last_res_cyc), 64'd1);
        chk("wsetup_cycles", 64'(wsetup_cycles), 64'd10);
        chk("job1_data_bursts", 64'(data_runs), 64'd1);
        wait_drain();

        // Sparse input: one beat every third cycle.
        wsetup_cycles = 0; data_runs = 0;
        send_cmd(16'd2);
        send_tiles(2, 2, 16'h0200, 1'b1);
        wait_done(dcyc);
        chk("sparse_data_bursts", 64'(data_runs), 64'd2);
        chk("sparse_wsetup_cycles", 64'(wsetup_cycles), 64'd10);
        wait_drain();

        // Output backpressure: credit must hold the third tile back.
        data_runs = 0;
        @(negedge clk);
        bus.m_ready = 1'b0;
        send_cmd(16'd4);
        fork
            send_tiles(4, 0, 16'h0300, 1'b1);
            begin
                repeat (150) @(negedge clk);
                #2;
                chk("bp_bursts_held", 64'(data_runs), 64'd2);
                chk("bp_no_burst_active", 64'(run_len), 64'd0);
                chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
                chk("bp_err", 64'(err_overflow), 64'd0);
                @(negedge clk);
                bus.m_ready = 1'b1;
            end
        join
        wait_done(dcyc);
        chk("bp_all_bursts", 64'(data_runs), 64'd4);
        chk("bp_err_final", 64'(err_overflow), 64'd0);
        wait_drain();

        // Weight-only job.
        data_runs = 0; w_runs = 0;
        send_cmd(16'd0);
        send_tiles(0, 0, 16'h0000, 1'b0);
        wait_done(dcyc);
        chk("w_only_done_lat", 64'(dcyc - last_w_cyc), 64'd1);
        chk("w_only_w_bursts", 64'(w_runs), 64'd1);
        chk("w_only_data_bursts", 64'(data_runs), 64'd0);

        // Forced overflow: nine unsolicited results into an eight-deep FIFO.
        @(negedge clk);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) res_q.push_back(64'hDEAD_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 8; i++) sb_q.push_back(64'hDEAD_0000_0000_0000 + 64'(i));
        repeat (15) @(negedge clk);
        #2;
        chk("ovf_err_set", 64'(err_overflow), 64'd1);
        chk("ovf_m_valid", 64'(bus.m_valid), 64'd1);
        chk("ovf_head", bus.m_data, 64'hDEAD_0000_0000_0000);
        send_cmd(16'd0);
        send_tiles(0, 0, 16'h0000, 1'b0);
        wait_done(dcyc);
        chk("ovf_err_stays_clear", 64'(err_overflow), 64'd0);
        @(negedge clk);
        bus.m_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a data burst, with stale results in the FIFO.
        @(negedge clk);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) res_q.push_back(64'hBEEF_0000_0000_0000 + 64'(i));
        send_cmd(16'd2);
        send_tiles(1, 0, 16'h0400, 1'b0);
        begin
            int guard;
            guard = 0;
            while (!(run_len > 0 && !run_w) && guard < 50) begin
                @(negedge clk);
                #2;
                guard++;
            end
            if (guard >= 50) fail("burst_wait_timeout", "data burst never started");
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_acc_rst_now", 64'(acc_rst), 64'd1);
        @(negedge clk);
        #2;
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("midrst_acc_data", acc_data, 64'd0);
        chk("midrst_acc_rst_held", 64'(acc_rst), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        #2;
        chk("postrst_acc_rst", 64'(acc_rst), 64'd0);
        repeat (20) @(negedge clk);
        #2;
        chk("postrst_idle", 64'(bus.cmd_ready), 64'd1);
        chk("postrst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
